// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Three requesters share one Binary_to_BCD converter and one display.
package ssd_pkg;

  localparam int NREQ  = 3;
  localparam int BIN_W = 10;
  localparam int BCD_W = 16;

  // Source index shown on the display when nobody owns it yet.
  localparam logic [1:0] SRC_NONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Turns a one-hot grant into the requester index it selects.
  function automatic logic [1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ssd_arbiter_rr_arb3.sv
// Combinational three-way round-robin picker.
// The search starts just after the last granted requester so that
// every pending requester is served in rotation.
module rr_arb3
  import ssd_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last_grant,
  output logic [NREQ-1:0] grant,
  output logic            valid
);

  // Priority chain rotated by the last grant; at most one bit is set.
  always_comb begin
    grant = '0;
    valid = |req;
    case (last_grant)
      2'd0: begin
        if      (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
      end
      2'd1: begin
        if      (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
      end
      default: begin
        if      (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/ssd_arbiter.sv
// Display arbiter: grants one requester at a time, runs its value through
// the shared BCD converter, then keeps the result on the display for
// DWELL_CYC cycles before serving the next requester.
// Optional feature: define SSD_ARB_TMO_EN to abort a conversion that gets
// no bcd_done within TMO_CYC cycles and raise the sticky err flag.
module ssd_arbiter
  import ssd_pkg::*;
#(
  parameter int DWELL_CYC = 50_000_000,
  parameter int TMO_CYC   = 1023
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NREQ-1:0]  req,
  input  logic [BIN_W-1:0] din0,
  input  logic [BIN_W-1:0] din1,
  input  logic [BIN_W-1:0] din2,
  output logic [NREQ-1:0]  ack,
  output logic             bcd_start,
  output logic [BIN_W-1:0] bcd_bin,
  input  logic             bcd_done,
  input  logic [BCD_W-1:0] bcd_in,
  output logic [BCD_W-1:0] disp_bcd,
  output logic [1:0]       disp_src,
  output logic             busy,
  output logic             err
);

  if (DWELL_CYC < 1 || DWELL_CYC > 134217727) begin : g_dwell_range
    $error("ssd_arbiter: DWELL_CYC must be in 1..2^27-1");
  end
  if (TMO_CYC < 1) begin : g_tmo_range
    $error("ssd_arbiter: TMO_CYC must be at least 1");
  end

  localparam logic [26:0] DWELL_LIM = 27'(DWELL_CYC - 1);

  state_t           state;
  state_t           next_state;
  logic [NREQ-1:0]  grant;
  logic             arb_valid;
  logic [1:0]       last_grant;
  logic [BIN_W-1:0] sel_din;
  logic [26:0]      dwell_cnt;
  logic             dwell_done;
  logic             take_grant;
  logic             take_done;
  logic             tmo_expire;

  rr_arb3 u_rr_arb3 (
    .req        (req),
    .last_grant (last_grant),
    .grant      (grant),
    .valid      (arb_valid)
  );

  // Operand of the requester the picker selected this cycle.
  always_comb begin
    sel_din = '0;
    case (grant)
      3'b001:  sel_din = din0;
      3'b010:  sel_din = din1;
      3'b100:  sel_din = din2;
      default: sel_din = '0;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic; requests are only looked at while idle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (arb_valid) next_state = CONV;
      CONV: begin
        if (bcd_done)        next_state = HOLD;
        else if (tmo_expire) next_state = IDLE;
      end
      HOLD: if (dwell_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Decoded per-state conditions shared by the FSM and the datapath.
  always_comb begin
    busy       = (state != IDLE);
    take_grant = (state == IDLE) && arb_valid;
    take_done  = (state == CONV) && bcd_done;
    dwell_done = (dwell_cnt >= DWELL_LIM);
  end

  // Grant pulses, operand latch, display latch and rotation pointer.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      ack        <= '0;
      bcd_start  <= 1'b0;
      bcd_bin    <= '0;
      disp_bcd   <= '0;
      disp_src   <= SRC_NONE;
      last_grant <= 2'd2;
    end else begin
      ack       <= '0;
      bcd_start <= 1'b0;
      if (take_grant) begin
        ack        <= grant;
        bcd_start  <= 1'b1;
        bcd_bin    <= sel_din;
        last_grant <= onehot_to_idx(grant);
      end
      if (take_done) begin
        disp_bcd <= bcd_in;
        disp_src <= last_grant;
      end
    end
  end

  // Dwell counter: held at zero until HOLD, then counts up and saturates.
  always_ff @(posedge CLK) begin
    if (!RST)                               dwell_cnt <= '0;
    else if (state != HOLD)                 dwell_cnt <= '0;
    else if (!dwell_done)                   dwell_cnt <= dwell_cnt + 27'd1;
  end

`ifdef SSD_ARB_TMO_EN
  localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_CYC - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             err_flag;

  assign tmo_hit    = (tmo_cnt >= TMO_LIM);
  assign tmo_expire = (state == CONV) && !bcd_done && tmo_hit;
  assign err        = err_flag;

  // Timeout counter runs only while a conversion is outstanding.
  always_ff @(posedge CLK) begin
    if (!RST)                 tmo_cnt <= '0;
    else if (state != CONV)   tmo_cnt <= '0;
    else if (!tmo_hit)        tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (!RST)            err_flag <= 1'b0;
    else if (tmo_expire) err_flag <= 1'b1;
  end
`else
  assign tmo_expire = 1'b0;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_ssd_arbiter.sv
// Scoreboard bench for ssd_arbiter with short dwell and timeout values.
// Expected grants are queued when requests are driven and popped when an
// ack appears; the bench plays the BCD converter itself.
module tb_ssd_arbiter;

  localparam int DWELL = 4;
  localparam int TMO   = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [2:0]  req = '0;
  logic [9:0]  din0 = '0, din1 = '0, din2 = '0;
  logic        bcd_done = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [2:0]  ack;
  logic        bcd_start;
  logic [9:0]  bcd_bin;
  logic [15:0] disp_bcd;
  logic [1:0]  disp_src;
  logic        busy;
  logic        err;

  typedef struct packed {
    logic [2:0] ack;
    logic [9:0] bin;
    logic [1:0] src;
  } grant_t;

  grant_t expQ[$];
  grant_t cur;
  int compared   = 0;
  int mismatched = 0;

  ssd_arbiter #(.DWELL_CYC(DWELL), .TMO_CYC(TMO)) dut (
    .CLK(CLK), .RST(RST), .req(req), .din0(din0), .din1(din1), .din2(din2),
    .ack(ack), .bcd_start(bcd_start), .bcd_bin(bcd_bin), .bcd_done(bcd_done),
    .bcd_in(bcd_in), .disp_bcd(disp_bcd), .disp_src(disp_src), .busy(busy),
    .err(err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [15:0] toBcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic [9:0] d0,
                               input logic [9:0] d1, input logic [9:0] d2);
    req  = r;
    din0 = d0;
    din1 = d1;
    din2 = d2;
  endtask

  task automatic applyReset();
    RST      = 1'b0;
    req      = '0;
    bcd_done = 1'b0;
    tick();
    tick();
    RST = 1'b1;
  endtask

  // Waits for the next ack and checks it against the oldest expectation.
  task automatic awaitGrant(input bit dropReq, input int expLat);
    int lat;
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      lat++;
      if (ack != 3'b000) break;
    end
    if (ack == 3'b000) begin
      checkOutput("grant_timeout", 32'd0, 32'd1);
      return;
    end
    if (expQ.size() == 0) begin
      checkOutput("unexpected_ack", 32'(ack), 32'd0);
      return;
    end
    cur = expQ.pop_front();
    checkOutput("ack", 32'(ack), 32'(cur.ack));
    checkOutput("bcd_start", 32'(bcd_start), 32'd1);
    checkOutput("bcd_bin", 32'(bcd_bin), 32'(cur.bin));
    if (expLat > 0) checkOutput("grant_latency", 32'(lat), 32'(expLat));
    if (dropReq) req = req & ~ack;
  endtask

  // Acts as the converter: answers after a delay, then checks the display.
  task automatic finishConversion(input int delay);
    for (int i = 0; i < delay; i++) begin
      tick();
      checkOutput("conv_ack", 32'(ack), 32'd0);
      checkOutput("conv_start", 32'(bcd_start), 32'd0);
    end
    bcd_in   = toBcd(int'(cur.bin));
    bcd_done = 1'b1;
    tick();
    bcd_done = 1'b0;
    bcd_in   = '0;
    checkOutput("disp_bcd", 32'(disp_bcd), 32'(toBcd(int'(cur.bin))));
    checkOutput("disp_src", 32'(disp_src), 32'(cur.src));
    checkOutput("busy_hold", 32'(busy), 32'd1);
  endtask

  // Counts HOLD cycles, making sure no request is acknowledged meanwhile.
  task automatic checkHold();
    int n;
    n = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!busy) break;
      checkOutput("hold_ack", 32'(ack), 32'd0);
      n++;
    end
    checkOutput("dwell_len", 32'(n), 32'(DWELL));
  endtask

  initial begin
    int n;

    // Reset values
    RST = 1'b0;
    tick();
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_start", 32'(bcd_start), 32'd0);
    checkOutput("rst_bin", 32'(bcd_bin), 32'd0);
    checkOutput("rst_disp", 32'(disp_bcd), 32'h0000);
    checkOutput("rst_src", 32'(disp_src), 32'd3);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    applyReset();

    // Single request, converter answers 12 cycles after start
    applyStimulus(3'b001, 10'd345, 10'd0, 10'd0);
    expQ.push_back('{ack: 3'b001, bin: 10'd345, src: 2'd0});
    awaitGrant(1'b1, 1);
    finishConversion(11);
    checkOutput("disp_0345", 32'(disp_bcd), 32'h0345);
    checkHold();

    // Stray bcd_done while idle leaves the display alone
    bcd_in   = 16'h9999;
    bcd_done = 1'b1;
    tick();
    bcd_done = 1'b0;
    tick();
    checkOutput("idle_done_disp", 32'(disp_bcd), 32'h0345);
    checkOutput("idle_done_busy", 32'(busy), 32'd0);

    // All three requesting: served in rotation starting at requester 0
    applyReset();
    applyStimulus(3'b111, 10'd1, 10'd22, 10'd999);
    expQ.push_back('{ack: 3'b001, bin: 10'd1,   src: 2'd0});
    expQ.push_back('{ack: 3'b010, bin: 10'd22,  src: 2'd1});
    expQ.push_back('{ack: 3'b100, bin: 10'd999, src: 2'd2});
    expQ.push_back('{ack: 3'b001, bin: 10'd1,   src: 2'd0});
    for (int g = 0; g < 4; g++) begin
      awaitGrant(1'b0, 1);
      if (g == 3) req = '0;
      finishConversion(3);
      checkHold();
    end
    tick();
    checkOutput("idle_no_ack", 32'(ack), 32'd0);

    // Requests during CONV/HOLD wait; one dropped before grant is never served
    applyReset();
    applyStimulus(3'b001, 10'd7, 10'd512, 10'd300);
    expQ.push_back('{ack: 3'b001, bin: 10'd7, src: 2'd0});
    awaitGrant(1'b1, 1);
    req = 3'b100;
    finishConversion(2);
    req = 3'b010;
    expQ.push_back('{ack: 3'b010, bin: 10'd512, src: 2'd1});
    checkHold();
    awaitGrant(1'b1, 1);
    finishConversion(0);
    checkHold();
    tick();
    checkOutput("dropped_no_ack", 32'(ack), 32'd0);

    // Converter never answers
    applyReset();
    applyStimulus(3'b001, 10'd100, 10'd0, 10'd0);
    expQ.push_back('{ack: 3'b001, bin: 10'd100, src: 2'd0});
    awaitGrant(1'b1, 1);
    n = 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!busy) break;
      checkOutput("tmo_start", 32'(bcd_start), 32'd0);
      n++;
    end
`ifdef SSD_ARB_TMO_EN
    checkOutput("tmo_len", 32'(n), 32'(TMO));
    checkOutput("tmo_err", 32'(err), 32'd1);
    tick();
    checkOutput("tmo_err_sticky", 32'(err), 32'd1);
`else
    checkOutput("no_tmo_len", 32'(n), 32'd31);
    checkOutput("no_tmo_err", 32'(err), 32'd0);
`endif
    checkOutput("tmo_disp", 32'(disp_bcd), 32'h0000);
    checkOutput("tmo_src", 32'(disp_src), 32'd3);

    // Reset in the middle of a conversion, then a late bcd_done
    applyReset();
    applyStimulus(3'b001, 10'd55, 10'd0, 10'd0);
    expQ.push_back('{ack: 3'b001, bin: 10'd55, src: 2'd0});
    awaitGrant(1'b1, 1);
    tick();
    tick();
    RST = 1'b0;
    tick();
    RST      = 1'b1;
    bcd_in   = toBcd(55);
    bcd_done = 1'b1;
    tick();
    bcd_done = 1'b0;
    bcd_in   = '0;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_disp", 32'(disp_bcd), 32'h0000);
    checkOutput("midrst_src", 32'(disp_src), 32'd3);
    checkOutput("midrst_ack", 32'(ack), 32'd0);
    tick();
    checkOutput("midrst_idle", 32'(busy), 32'd0);
    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ssd_arbiter.md
SSD_ARBITER -- requirements
Module: ssd_arbiter

Interface
REQ-001 Parameter: DWELL_CYC, 50_000_000, cycles a granted value stays on the display (legal range 1..2^27-1).
REQ-002 Parameter: TMO_CYC, 1023, cycles to wait for converter done before abort (used only with SSD_ARB_TMO_EN).
REQ-003 Port: CLK  input  1  single system clock; all logic on its rising edge.
REQ-004 Port: RST  input  1  reset, synchronous, active-low.
REQ-005 Port: req  input  3  per-requester level request; held until matching ack.
REQ-006 Port: din0, din1, din2  input  10 each  binary value of requester 0/1/2, valid while its req is high.
REQ-007 Port: ack  output  3  one-cycle grant pulse, one-hot.
REQ-008 Port: bcd_start  output  1  one-cycle start pulse to the shared Binary_to_BCD converter.
REQ-009 Port: bcd_bin  output  10  operand to the converter, stable from bcd_start until done.
REQ-010 Port: bcd_done  input  1  converter completion pulse.
REQ-011 Port: bcd_in  input  16  converter result, 4 BCD digits, valid with bcd_done.
REQ-012 Port: disp_bcd  output  16  digits for the scanning display driver.
REQ-013 Port: disp_src  output  2  index of requester currently shown (3 = none).
REQ-014 Port: busy  output  1  high in every state except IDLE.
REQ-015 Port: err  output  1  sticky converter-timeout flag (tied 0 without SSD_ARB_TMO_EN).

Function
REQ-016 FSM states IDLE, CONV, HOLD; one-hot or binary encoding at implementer's choice.
REQ-017 IDLE with any req high: pick winner by round-robin starting at (last_grant+1) mod 3; next cycle ack[winner]=1, bcd_start=1, bcd_bin=din[winner] latched, state CONV.
REQ-018 IDLE with req all low: stay IDLE, all pulses low.
REQ-019 Simultaneous requests: only one ack per grant; losers stay pending and are served in rotation order.
REQ-020 req dropped before grant: not served; no ack issued.
REQ-021 CONV: wait for bcd_done; on the cycle bcd_done=1, next cycle disp_bcd<=bcd_in, disp_src<=winner, state HOLD, dwell counter cleared.
REQ-022 HOLD: count exactly DWELL_CYC cycles, then IDLE; req ignored (no ack) during CONV and HOLD.
REQ-023 bcd_done in IDLE or HOLD: ignored; disp_bcd unchanged.
REQ-024 bcd_start never re-asserted before done or abort of the current conversion.
REQ-025 Dwell counter 27 bits, saturating compare, no wrap.
REQ-026 last_grant updates only on a grant; initial value 2 so requester 0 wins first after reset.

Reset
REQ-027 RST low at a rising edge: state IDLE, ack=0, bcd_start=0, bcd_bin=0, disp_bcd=16'h0000, disp_src=3, busy=0, err=0, counters 0, last_grant=2.
REQ-028 Reset mid-CONV or mid-HOLD: abandoned immediately; a later stray bcd_done is ignored.

Configuration
REQ-029 Macro SSD_ARB_TMO_EN defined: CONV counts cycles; at TMO_CYC cycles without bcd_done go IDLE, set err (sticky until reset), disp_bcd/disp_src unchanged.
REQ-030 SSD_ARB_TMO_EN undefined: no timeout counter, CONV waits indefinitely, err constant 0.

Structure
REQ-031 Package ssd_pkg holds: state enum, NREQ=3, BIN_W=10, BCD_W=16, SRC_NONE=2'd3.
REQ-032 Sub-module rr_arb3: combinational 3-way round-robin picker (req, last_grant -> grant one-hot, valid).
REQ-033 Top holds FSM, latches, dwell and timeout counters only.

Verification
REQ-034 Reset, req=3'b001, din0=10'd345, done 12 cycles after start with bcd_in=16'h0345 -> ack=001 next cycle, bcd_bin=345, disp_bcd=0345, disp_src=0.
REQ-035 req=3'b111 held, DWELL_CYC=4 -> ack sequence 001,010,100,001; each grant 4 cycles after previous display update plus conversion.
REQ-036 req1 asserted during HOLD -> no ack until IDLE, then ack=010.
REQ-037 TMO_EN, TMO_CYC=8, no bcd_done -> IDLE after 8 cycles, err=1, disp_bcd unchanged; without macro -> stays CONV, err=0.
REQ-038 RST low mid-CONV, then bcd_done pulse -> IDLE, disp_bcd=0000, disp_src=3, no update.
